// File: rtl/instruction_loader.sv
// Assembles a UART byte stream (MSB first) into instruction words and writes them
// to instruction memory from address 0 until a HALT word or the memory fills.
// Optional mid-word idle timeout: define LOADER_TIMEOUT_EN.
module instruction_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_DEPTH     = 128,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_pcWrite,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(DATA_DEPTH - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("instruction_loader: illegal parameter combination");
  end

  typedef enum logic [1:0] {LOAD, DONE, ERROR} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
  logic                  pc_write_q, pc_write_d;
  logic [DATA_WIDTH-1:0] word;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_expire;

  // Counts consecutive idle cycles while a partial word is pending.
  always_comb begin
    tmo_cnt_d  = '0;
    tmo_expire = 1'b0;
    if (state_q == LOAD && byte_cnt_q != '0 && !i_rx_valid) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_expire = 1'b1;
      else                                          tmo_cnt_d  = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    wr_addr_d     = wr_addr_q;
    address_d     = address_q;
    instruction_d = instruction_q;
    pc_write_d    = 1'b0;
    // Truncating cast keeps the low bits: the oldest byte falls off the top.
    word          = DATA_WIDTH'({shift_q, i_rx_data});

    if (state_q == LOAD) begin
      if (i_rx_valid) begin
        shift_d = word;
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d    = '0;
          pc_write_d    = 1'b1;
          address_d     = wr_addr_q;
          instruction_d = word;
          wr_addr_d     = wr_addr_q + 1'b1;
          if (word[DATA_WIDTH-1 -: 6] == 6'b111111) state_d = DONE;
          else if (wr_addr_q == LAST_ADDR)          state_d = ERROR;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
`ifdef LOADER_TIMEOUT_EN
      else if (tmo_expire) begin
        byte_cnt_d = '0;
        shift_d    = '0;
      end
`endif
    end
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch with no edge on i_reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q       <= LOAD;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      wr_addr_q     <= '0;
      address_q     <= '0;
      instruction_q <= '0;
      pc_write_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      wr_addr_q     <= wr_addr_d;
      address_q     <= address_d;
      instruction_q <= instruction_d;
      pc_write_q    <= pc_write_d;
    end
  end

  assign o_pcWrite     = pc_write_q;
  assign o_address     = address_q;
  assign o_instruction = instruction_q;
  assign o_done        = (state_q == DONE);
  assign o_error       = (state_q == ERROR);

endmodule
